// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} mem_size_t;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} dmem_state_t;

  localparam int DMEM_LAT_W = 4;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return |a;
    endcase
  endfunction

  // Natural alignment of the in-word offset; reserved size 11 aligns like a word.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables/data and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        is_unsigned,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    be      = 4'hF;
    st_data = wdata;
    ld_data = rword;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        st_data = {4{wdata[7:0]}};
        ld_data = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
        ld_data = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be      = 4'hF;
        st_data = wdata;
        ld_data = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable latency.
// Optional access-fault checking is enabled by defining DMEM_ACCESS_FAULT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t           state_reg, state_next;
  logic [DMEM_LAT_W-1:0] cnt_reg, cnt_next;
  logic                  ready_reg;
  logic                  we_reg, uns_reg;
  logic [1:0]            size_reg;
  logic [31:0]           addr_reg, wdata_reg;
  logic [31:0]           rdata_reg;
  logic                  err_reg;

  logic                  accept, access, fault;
  logic                  op_we, op_uns;
  logic [1:0]            op_size;
  logic [31:0]           op_addr, op_wdata;
  logic [AW-1:0]         word_idx;
  logic [3:0]            be;
  logic [31:0]           st_data, ld_data, rword;
  logic [31:0]           mem [DEPTH];

  assign accept    = req_valid && ready_reg;
  assign req_ready = ready_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  // With LATENCY = 1 the access edge is the acceptance edge, so use the live request then.
  always_comb begin
    if (state_reg == IDLE) begin
      op_we = req_we;  op_uns = req_unsigned; op_size = req_size;
      op_addr = req_addr; op_wdata = req_wdata;
    end else begin
      op_we = we_reg;  op_uns = uns_reg; op_size = size_reg;
      op_addr = addr_reg; op_wdata = wdata_reg;
    end
  end

`ifdef DMEM_ACCESS_FAULT_EN
  assign fault = misaligned(op_size, op_addr[1:0]) || (op_addr[31:AW+2] != '0);
`else
  logic unused_hi;
  assign fault     = 1'b0;
  assign unused_hi = ^op_addr[31:AW+2];
`endif

  assign word_idx = op_addr[AW+1:2];
  assign rword    = mem[word_idx];

  dmem_lane_align u_align (
    .size        (op_size),
    .addr_lo     (align_lo(op_size, op_addr[1:0])),
    .wdata       (op_wdata),
    .rword       (rword),
    .is_unsigned (op_uns),
    .be          (be),
    .st_data     (st_data),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
          cnt_next   = DMEM_LAT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == DMEM_LAT_W'(1)) state_next = RESP;
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign access = (state_next == RESP) && (state_reg != RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= (state_next == IDLE);
      if (accept) begin
        we_reg    <= req_we;
        uns_reg   <= req_unsigned;
        size_reg  <= req_size;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (access) begin
        rdata_reg <= (op_we || fault) ? 32'h0 : ld_data;
        err_reg   <= fault;
      end
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (access && op_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH = 64, LATENCY = 2).
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int nvec = 0;
  int nerr = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    check({tag, "_accept"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    $display("txn %s we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             tag, we, sz, addr, wd, rsp_rdata, rsp_err, n);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready_low", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check("rel_ready_high", {31'h0, req_ready}, 32'h1);

    // Word store / load
    txn("sw64", 1'b1, 2'b10, 1'b0, 32'h64, 32'h00000019, 32'h0, 1'b0);
    txn("lw64", 1'b0, 2'b10, 1'b0, 32'h64, 32'h0, 32'h00000019, 1'b0);

    // Byte lanes
    txn("sw60", 1'b1, 2'b10, 1'b0, 32'h60, 32'h11223344, 32'h0, 1'b0);
    txn("sb61", 1'b1, 2'b00, 1'b0, 32'h61, 32'h00000080, 32'h0, 1'b0);
    txn("lb61", 1'b0, 2'b00, 1'b0, 32'h61, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("lbu61", 1'b0, 2'b00, 1'b1, 32'h61, 32'h0, 32'h00000080, 1'b0);
    txn("lw60", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'h11228044, 1'b0);

    // Halfword lanes
    txn("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h55667788, 32'h0, 1'b0);
    txn("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0);
    txn("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);
    txn("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
    txn("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF7788, 1'b0);

    // Back-pressure: response held 5+ cycles, a second request waits behind it
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h60;
    @(negedge clk);
    check("bp_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1 req_addr = 32'h64;
    @(negedge clk);
    check("bp_wait", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("bp_valid", {31'h0, rsp_valid}, 32'h1);
    check("bp_rdata", rsp_rdata, 32'h11228044);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_hold_rdata", rsp_rdata, 32'h11228044);
      check("bp_hold_ready", {31'h0, req_ready}, 32'h0);
    end
    $display("txn bp_lw60 held rdata=%h for 5 stalled cycles", rsp_rdata);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_done_valid", {31'h0, rsp_valid}, 32'h0);
    check("bp_done_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    check("bp2_lat", n, LAT);
    check("bp2_rdata", rsp_rdata, 32'h00000019);
    $display("txn bp_lw64 rdata=%h lat=%0d", rsp_rdata, n);
    @(posedge clk);

    // Reset while a store is waiting: it must be dropped
    txn("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rm_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rm_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    $display("txn rm_sw20 dropped by reset");
    txn("rm_lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

    txn("sw00", 1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE0001, 32'h0, 1'b0);
`ifdef DMEM_ACCESS_FAULT_EN
    txn("f_lw22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
    txn("f_sw100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("f_lw00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hCAFE0001, 1'b0);
    txn("f_lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);
`else
    txn("wrap_lw102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hCAFE0001, 1'b0);
    txn("wrap_lh63", 1'b0, 2'b01, 1'b1, 32'h63, 32'h0, 32'h00001122, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
